// File: rtl/seg7_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Entry k is the pattern for hex digit k (entry 15 is listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment driver: per-frame input latch, digit
// dwell/blank sequencing on scan_tap rising edges, active-low anode/segment outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL_TICKS = 3,
  parameter int BLANK_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_tap,
  input  logic [31:0] data,
  input  logic [7:0]  point,
  input  logic [7:0]  le,
  input  logic        lz_sup,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [3:0] DWELL_LAST = 4'(DWELL_TICKS - 1);
  localparam logic [3:0] BLANK_LAST = (BLANK_TICKS == 0) ? 4'd0 : 4'(BLANK_TICKS - 1);

  scan_state_t state_reg, state_next;
  logic [2:0]  digit_reg, digit_next;
  logic [3:0]  tick_cnt_reg, tick_cnt_next;
  logic        tap_q_reg;
  logic        frame_done_reg, frame_done_next;
  logic [7:0]  an_reg, an_next;
  logic [7:0]  seg_reg, seg_next;

  logic [31:0] data_sh_reg;
  logic [7:0]  point_sh_reg;
  logic [7:0]  le_sh_reg;
  logic        lz_sh_reg;

  logic        tick;
  logic        advance;
  logic [7:0]  nib_nz;
  logic [7:0]  show;
  logic [2:0]  msd;
  logic [3:0]  cur_nibble;
  logic [6:0]  dec_seg;

  assign tick = scan_tap & ~tap_q_reg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
    assign nib_nz[gi] = |data_sh_reg[4*gi +: 4];
  end

  // Highest nonzero nibble of the latched word; stays 0 for an all-zero word.
  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nib_nz[i]) msd = 3'(i);
    end
  end

  // Digit 0 always satisfies d <= msd, so it is only ever gated by le.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_show
    assign show[gi] = le_sh_reg[gi] & (~lz_sh_reg | (3'(gi) <= msd));
  end

  assign cur_nibble = data_sh_reg[4*digit_reg +: 4];

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg_n  (dec_seg)
  );

  always_comb begin
    state_next      = state_reg;
    digit_next      = digit_reg;
    tick_cnt_next   = tick_cnt_reg;
    frame_done_next = 1'b0;
    advance         = 1'b0;

    case (state_reg)
      LOAD: begin
        digit_next    = 3'd0;
        tick_cnt_next = 4'd0;
        state_next    = DRIVE;
      end
      DRIVE: begin
        if (tick) begin
          if (tick_cnt_reg == DWELL_LAST) begin
            tick_cnt_next = 4'd0;
            if (BLANK_TICKS == 0) advance = 1'b1;
            else                  state_next = BLANK;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end
      BLANK: begin
        if (tick) begin
          if (tick_cnt_reg == BLANK_LAST) begin
            tick_cnt_next = 4'd0;
            advance       = 1'b1;
          end else begin
            tick_cnt_next = tick_cnt_reg + 4'd1;
          end
        end
      end
      default: state_next = LOAD;
    endcase

    // Leaving a digit: either step to the next one or close the frame via LOAD.
    if (advance) begin
      if (digit_reg == 3'd7) begin
        frame_done_next = 1'b1;
        state_next      = LOAD;
      end else begin
        digit_next = digit_reg + 3'd1;
        state_next = DRIVE;
      end
    end
  end

  always_comb begin
    an_next  = SEG_OFF;
    seg_next = SEG_OFF;
    if (state_reg == DRIVE) begin
      seg_next = {~point_sh_reg[digit_reg], dec_seg};
      if (show[digit_reg]) an_next = ~(8'b1 << digit_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= LOAD;
      digit_reg      <= 3'd0;
      tick_cnt_reg   <= 4'd0;
      tap_q_reg      <= 1'b1;
      frame_done_reg <= 1'b0;
      an_reg         <= SEG_OFF;
      seg_reg        <= SEG_OFF;
      data_sh_reg    <= 32'd0;
      point_sh_reg   <= 8'd0;
      le_sh_reg      <= 8'd0;
      lz_sh_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      digit_reg      <= digit_next;
      tick_cnt_reg   <= tick_cnt_next;
      tap_q_reg      <= scan_tap;
      frame_done_reg <= frame_done_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      if (state_reg == LOAD) begin
        data_sh_reg  <= data;
        point_sh_reg <= point;
        le_sh_reg    <= le;
        lz_sh_reg    <= lz_sup;
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Checks two scanner instances (3/1 and 3/0 dwell/blank) against a slot-based
// reference model driven by the same bench-generated scan ticks.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_tap = 1'b0;
  logic [31:0] data = 32'd0;
  logic [7:0]  point = 8'd0;
  logic [7:0]  le = 8'd0;
  logic        lz_sup = 1'b0;
  logic [7:0]  an0, seg0, an1, seg1;
  logic        fd0, fd1;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt [2];
  int fd_base [2];
  int p [2];
  int frames [2];
  logic [31:0] m_data [2];
  logic [7:0]  m_point [2];
  logic [7:0]  m_le [2];
  logic        m_lz [2];

  seg7_scan_ctrl #(.DWELL_TICKS(3), .BLANK_TICKS(1)) dut0 (
    .clk(clk), .rst(rst), .scan_tap(scan_tap), .data(data), .point(point),
    .le(le), .lz_sup(lz_sup), .an(an0), .seg(seg0), .frame_done(fd0)
  );

  seg7_scan_ctrl #(.DWELL_TICKS(3), .BLANK_TICKS(0)) dut1 (
    .clk(clk), .rst(rst), .scan_tap(scan_tap), .data(data), .point(point),
    .le(le), .lz_sup(lz_sup), .an(an1), .seg(seg1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fd0) fd_cnt[0]++;
    if (fd1) fd_cnt[1]++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic int dwell_of(input int i);
    return 3;
  endfunction

  function automatic int blank_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic [6:0] hex_pattern(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Slot p of a frame: digit p/(D+B); the first D slots of each digit drive it, the rest are dark.
  task automatic expected(input int i, output logic [7:0] e_an, output logic [7:0] e_seg);
    int per, d, r, msd;
    logic show;
    per = dwell_of(i) + blank_of(i);
    d = p[i] / per;
    r = p[i] % per;
    e_an = 8'hFF;
    e_seg = 8'hFF;
    if (r < dwell_of(i)) begin
      msd = 0;
      for (int k = 0; k < 8; k++) if (m_data[i][4*k +: 4] != 4'h0) msd = k;
      show = m_le[i][d] && (!m_lz[i] || d <= msd);
      e_seg = {~m_point[i][d], hex_pattern(m_data[i][4*d +: 4])};
      if (show) e_an = ~(8'h01 << d);
    end
  endtask

  task automatic snapshot(input int i);
    m_data[i] = data;
    m_point[i] = point;
    m_le[i] = le;
    m_lz[i] = lz_sup;
  endtask

  task automatic model_restart();
    for (int i = 0; i < 2; i++) begin
      snapshot(i);
      p[i] = 0;
      frames[i] = 0;
      fd_base[i] = fd_cnt[i];
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      p[i]++;
      if (p[i] == 8 * (dwell_of(i) + blank_of(i))) begin
        p[i] = 0;
        frames[i]++;
        snapshot(i);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample_all();
    logic [7:0] ea, es;
    expected(0, ea, es);
    check("an0", {24'd0, an0}, {24'd0, ea});
    check("seg0", {24'd0, seg0}, {24'd0, es});
    check("frames0", fd_cnt[0] - fd_base[0], frames[0]);
    expected(1, ea, es);
    check("an1", {24'd0, an1}, {24'd0, ea});
    check("seg1", {24'd0, seg1}, {24'd0, es});
    check("frames1", fd_cnt[1] - fd_base[1], frames[1]);
    $display("tick: p0=%0d an0=%h seg0=%h | p1=%0d an1=%h seg1=%h", p[0], an0, seg0, p[1], an1, seg1);
  endtask

  // One scan_tap rising edge, held high for 1..3 clocks; only the first edge may count.
  task automatic do_tick();
    @(posedge clk);
    #1 scan_tap = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 scan_tap = 1'b0;
    model_tick();
    repeat ($urandom_range(2, 4)) @(posedge clk);
    @(negedge clk);
    sample_all();
  endtask

  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++) do_tick();
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an0"}, {24'd0, an0}, 32'hFF);
    check({tag, "_seg0"}, {24'd0, seg0}, 32'hFF);
    check({tag, "_an1"}, {24'd0, an1}, 32'hFF);
    check({tag, "_seg1"}, {24'd0, seg1}, 32'hFF);
    check({tag, "_fd"}, {30'd0, fd0, fd1}, 32'd0);
  endtask

  initial begin
    data = 32'h76543210;
    point = 8'h00;
    le = 8'hFF;
    lz_sup = 1'b0;

    // Reset held with the tap toggling.
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 scan_tap = ~scan_tap;
      @(negedge clk);
      check_dark("reset_hold");
    end

    // Release with the tap already high: no tick may be counted.
    @(posedge clk);
    #1 scan_tap = 1'b1;
    rst = 1'b1;
    model_restart();
    repeat (2) @(posedge clk);
    #1 scan_tap = 1'b0;
    @(negedge clk);
    check("basic_d0_an", {24'd0, an0}, 32'hFE);
    check("basic_d0_seg", {24'd0, seg0}, 32'hC0);
    sample_all();

    // Basic scan, with a word change while digit 3 is driving.
    run_ticks(13);
    data = 32'h000000A5;
    lz_sup = 1'b1;
    run_ticks(19);

    // Leading-zero frame, then an all-zero word.
    run_ticks(16);
    data = 32'h00000000;
    run_ticks(16);
    run_ticks(16);
    data = 32'h88888888;
    point = 8'h01;
    le = 8'hFD;
    lz_sup = 1'b0;
    run_ticks(16);
    run_ticks(32);

    // Randomized words, masks and options changed at random points.
    for (int t = 0; t < 200; t++) begin
      do_tick();
      if ($urandom_range(0, 7) == 0) begin
        logic [31:0] mask;
        int nz;
        mask = 32'd0;
        nz = $urandom_range(0, 8);
        for (int j = 0; j < nz; j++) mask[4*j +: 4] = 4'hF;
        data = $urandom & mask;
        point = 8'($urandom);
        le = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        lz_sup = 1'($urandom_range(0, 1));
      end
    end

    // Mid-frame reset while digit 5 of the 3/1 instance is driving.
    while (!(p[0] >= 20 && p[0] <= 22)) do_tick();
    data = $urandom;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_dark("mid_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    scan_tap = 1'b1;
    model_restart();
    @(posedge clk);
    #1 scan_tap = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sample_all();
    run_ticks(64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
